// File: rtl/world_pixel_source.sv
// rtl/world_pixel_source.sv - 640x480@60 VGA timing with a world-map pixel fetch aligned to the timing outputs
module world_pixel_source #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int MAP_SHIFT = 2,
  parameter int MAP_COLS  = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  map_data,
  output logic [13:0] map_addr,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        video_on,
  output logic [9:0]  pixel_row,
  output logic [9:0]  pixel_column,
  output logic [1:0]  world_pixel
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  // The map may be narrower than the screen; one extra bit keeps the compare safe for any width.
  localparam logic [10:0] MAP_END  = 11'(MAP_COLS << MAP_SHIFT);

  // Stage 0: raster counters
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  // Stage 0 decode (combinational)
  logic        vis_s0;
  logic        hs_s0;
  logic        vs_s0;
  logic        in_map_s0;
  logic [13:0] addr_s0;

  // Stage 1: address issued to the map RAM, controls carried alongside
  logic        s1_vis_q, s1_vis_d;
  logic        s1_hs_q, s1_hs_d;
  logic        s1_vs_q, s1_vs_d;
  logic        s1_in_map_q, s1_in_map_d;
  logic [9:0]  s1_h_q, s1_h_d;
  logic [9:0]  s1_v_q, s1_v_d;
  logic [13:0] map_addr_q, map_addr_d;

  // Stage 2: map RAM is producing data for the stage-1 address
  logic        s2_vis_q, s2_vis_d;
  logic        s2_hs_q, s2_hs_d;
  logic        s2_vs_q, s2_vs_d;
  logic        s2_in_map_q, s2_in_map_d;
  logic [9:0]  s2_h_q, s2_h_d;
  logic [9:0]  s2_v_q, s2_v_d;

  // Stage 3: all outputs registered together
  logic        video_on_q, video_on_d;
  logic        horiz_sync_q, horiz_sync_d;
  logic        vert_sync_q, vert_sync_d;
  logic [9:0]  pixel_row_q, pixel_row_d;
  logic [9:0]  pixel_column_q, pixel_column_d;
  logic [1:0]  world_pixel_q, world_pixel_d;

  // Raster advance: h wraps every line, v steps only on h wrap
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 10'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  // Decode visibility, sync windows and map coverage from the raw counters
  always_comb begin
    vis_s0    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_s0     = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vs_s0     = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    in_map_s0 = vis_s0 && ({1'b0, h_cnt_q} < MAP_END);
    // One map cell covers 4x4 screen pixels; blanking addresses are harmless reads.
    addr_s0   = {v_cnt_q[8:2], h_cnt_q[8:2]};
  end

  // Stage 1 next state: launch the RAM read and capture the decoded controls
  always_comb begin
    s1_vis_d    = vis_s0;
    s1_hs_d     = hs_s0;
    s1_vs_d     = vs_s0;
    s1_in_map_d = in_map_s0;
    s1_h_d      = h_cnt_q;
    s1_v_d      = v_cnt_q;
    map_addr_d  = addr_s0;
  end

  // Stage 2 next state: hold the controls while the RAM read completes
  always_comb begin
    s2_vis_d    = s1_vis_q;
    s2_hs_d     = s1_hs_q;
    s2_vs_d     = s1_vs_q;
    s2_in_map_d = s1_in_map_q;
    s2_h_d      = s1_h_q;
    s2_v_d      = s1_v_q;
  end

  // Stage 3 next state: mask RAM data outside the map, zero coordinates in blanking
  always_comb begin
    video_on_d     = s2_vis_q;
    horiz_sync_d   = s2_hs_q;
    vert_sync_d    = s2_vs_q;
    pixel_row_d    = s2_vis_q ? s2_v_q : 10'd0;
    pixel_column_d = s2_vis_q ? s2_h_q : 10'd0;
    world_pixel_d  = s2_in_map_q ? map_data : 2'b00;
  end

  // Every stage updates each clock; reset parks syncs inactive so none glitch after release
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_q        <= 10'd0;
      v_cnt_q        <= 10'd0;
      s1_vis_q       <= 1'b0;
      s1_hs_q        <= 1'b1;
      s1_vs_q        <= 1'b1;
      s1_in_map_q    <= 1'b0;
      s1_h_q         <= 10'd0;
      s1_v_q         <= 10'd0;
      map_addr_q     <= 14'd0;
      s2_vis_q       <= 1'b0;
      s2_hs_q        <= 1'b1;
      s2_vs_q        <= 1'b1;
      s2_in_map_q    <= 1'b0;
      s2_h_q         <= 10'd0;
      s2_v_q         <= 10'd0;
      video_on_q     <= 1'b0;
      horiz_sync_q   <= 1'b1;
      vert_sync_q    <= 1'b1;
      pixel_row_q    <= 10'd0;
      pixel_column_q <= 10'd0;
      world_pixel_q  <= 2'b00;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      s1_vis_q       <= s1_vis_d;
      s1_hs_q        <= s1_hs_d;
      s1_vs_q        <= s1_vs_d;
      s1_in_map_q    <= s1_in_map_d;
      s1_h_q         <= s1_h_d;
      s1_v_q         <= s1_v_d;
      map_addr_q     <= map_addr_d;
      s2_vis_q       <= s2_vis_d;
      s2_hs_q        <= s2_hs_d;
      s2_vs_q        <= s2_vs_d;
      s2_in_map_q    <= s2_in_map_d;
      s2_h_q         <= s2_h_d;
      s2_v_q         <= s2_v_d;
      video_on_q     <= video_on_d;
      horiz_sync_q   <= horiz_sync_d;
      vert_sync_q    <= vert_sync_d;
      pixel_row_q    <= pixel_row_d;
      pixel_column_q <= pixel_column_d;
      world_pixel_q  <= world_pixel_d;
    end
  end

  assign map_addr     = map_addr_q;
  assign horiz_sync   = horiz_sync_q;
  assign vert_sync    = vert_sync_q;
  assign video_on     = video_on_q;
  assign pixel_row    = pixel_row_q;
  assign pixel_column = pixel_column_q;
  assign world_pixel  = world_pixel_q;

endmodule
